filter2d_wr: RTL and testbench

Result writer for the 2D filter datapath. Consumes the filter's per-pixel output strobe stream (one 8-bit pixel per strobe) and packs four pixels into 32-bit words. Writes the words to the output frame memory through a valid/ready write port. Buffers up to FIFO_DEPTH words against memory backpressure, and signals frame completion or data loss.

---
 rtl/filter2d_pkg.sv | 18 +
 rtl/filter2d_wr_fifo.sv | 74 +++++++
 rtl/filter2d_wr.sv | 173 +++++++++++++++++
 tb/tb_filter2d_wr.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter2d_pkg.sv
// Shared definitions for the 2D filter result writer.
//   PIX_W  : pixel width in bits
//   WORD_W : packed memory word width (four pixels)
//   ADDR_W : frame memory word address width
//   wr_state_e : writer control states
package filter2d_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wr_state_e;

endpackage

// File: rtl/filter2d_wr_fifo.sv
// Synchronous word FIFO for the filter2d result writer.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   flush      : synchronous clear, same effect as reset
//   push, din  : write request and data; ignored when full unless popping
//   pop        : read request; ignored when empty
//   dout       : head word, forced to 0 while empty
//   empty/full : occupancy flags
//   level      : number of stored words
module filter2d_wr_fifo
  import filter2d_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign level = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/filter2d_wr.sv
// filter2d_wr: result writer for the 2D filter datapath.
// Packs four 8-bit strobed pixels into one 32-bit word (pixel n in byte n%4),
// buffers words in a FIFO and writes them to frame memory over a
// valid/ready port with an incrementing word address.
//   clk, reset        : clock, synchronous active-high reset
//   start             : pulse, begins or restarts a frame capture
//   i_strb, i_data    : pixel strobe and value
//   wr_en, wr_addr,
//   wr_data, wr_ready : memory write port, transfer on wr_en && wr_ready
//   busy              : capturing or draining a frame
//   done              : one-cycle pulse after the last word of a frame is written
//   overflow          : sticky, a word was dropped on a full FIFO
//   csum              : mod-2^16 sum of the frame's accepted pixels
// Optional feature macro: FILTER2D_WR_CSUM_EN builds the checksum
// accumulator; without it csum reads 0.
module filter2d_wr
  import filter2d_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              i_strb,
  input  logic [PIX_W-1:0]  i_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       csum
);

  localparam int TOTAL = WIDTH * WIDTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [23:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              accept;
  logic [1:0]        lane;
  logic              push;
  logic              pop;
  logic              drop;
  logic [WORD_W-1:0] push_word;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LVL_W-1:0]  fifo_level;

  assign lane      = pix_cnt_q[1:0];
  assign accept    = (state_q == ST_RUN) && i_strb && !start;
  assign push      = accept && (lane == 2'd3);
  assign push_word = {i_data, pack_q};
  assign wr_en     = !fifo_empty;
  assign pop       = wr_en && wr_ready;
  assign drop      = push && fifo_full && !pop;

  assign wr_addr  = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

  filter2d_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (wr_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    pack_d    = pack_q;
    addr_d    = addr_q + {{(ADDR_W-1){1'b0}}, pop};
    ovf_d     = ovf_q | drop;
    done_d    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == CNT_W'(TOTAL - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the last word transfers so done and the busy drop
        // appear together in the cycle after that transfer.
        if (fifo_empty || (fifo_level == LVL_W'(1) && pop)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase

    if (accept) begin
      case (lane)
        2'd0:    pack_d[7:0]   = i_data;
        2'd1:    pack_d[15:8]  = i_data;
        2'd2:    pack_d[23:16] = i_data;
        default: pack_d        = '0;
      endcase
    end

    if (start) begin
      state_d   = ST_RUN;
      pix_cnt_d = '0;
      pack_d    = '0;
      addr_d    = '0;
      ovf_d     = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    pack_q <= pack_d;
  end

`ifdef FILTER2D_WR_CSUM_EN
  logic [15:0] csum_q, csum_d;

  // Counts every accepted pixel, including those in dropped words; no
  // pixel is accepted outside RUN, so the sum freezes on DRAIN entry.
  always_comb begin
    csum_d = csum_q;
    if (start)       csum_d = '0;
    else if (accept) csum_d = csum_q + {8'd0, i_data};
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_filter2d_wr.sv
module tb_filter2d_wr;

  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int NPIX  = W * W;

  logic        clk;
  logic        reset;
  logic        start;
  logic        i_strb;
  logic [7:0]  i_data;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] csum;

  filter2d_wr #(
    .WIDTH      (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .i_strb   (i_strb),
    .i_data   (i_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .csum     (csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  base;
    int          gap;
    int          stall_at;
    int          stall_len;
    logic [31:0] w0;
    logic [31:0] w3;
    logic [15:0] sum;
  } frame_vec_t;

  wr_t         sb_q[$];
  frame_vec_t  vecs[4];
  logic [31:0] cap[16];

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int n_done  = 0;
  int cyc_n   = 0;
  int last_xfer_cyc = -100;
  logic [15:0] done_csum;
  logic        done_ovf;

  // bench-side reference state
  int          k_pix;
  logic [31:0] m_word;
  logic [13:0] m_addr;
  logic [15:0] m_sum;
  logic        m_ovf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef FILTER2D_WR_CSUM_EN
    return s;
`else
    return (s & 16'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    k_pix  = 0;
    m_word = '0;
    m_addr = '0;
    m_sum  = '0;
    m_ovf  = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 16; i++) cap[i] = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_reset();
  endtask

  // Present one pixel for the coming edge and predict its effect.
  task automatic drive_pix(input logic [7:0] d);
    int  lane;
    wr_t e;
    i_strb = 1'b1;
    i_data = d;
    lane   = k_pix % 4;
    m_word[8*lane +: 8] = d;
    m_sum  = m_sum + {8'd0, d};
    if (lane == 3) begin
      if (sb_q.size() >= DEPTH && !wr_ready) begin
        m_ovf = 1'b1;
      end else begin
        e.addr = m_addr;
        e.data = m_word;
        sb_q.push_back(e);
        m_addr = m_addr + 14'd1;
      end
    end
    k_pix++;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200 && n_done == d0; i++) tick();
    check("done_pulse_count", n_done - d0, 1);
  endtask

  task automatic run_frame(input frame_vec_t v);
    int d0;
    int x0;
    d0 = n_done;
    x0 = n_xfer;
    do_start();
    for (int c = 0; k_pix < NPIX && c < 2000; c++) begin
      wr_ready = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
      if (c % v.gap == 0) drive_pix(v.base + 8'(k_pix));
      else i_strb = 1'b0;
      tick();
    end
    i_strb   = 1'b0;
    wr_ready = 1'b1;
    wait_done(d0);
    check("frame_writes", n_xfer - x0, 4);
    check("frame_word0", cap[0], v.w0);
    check("frame_word3", cap[3], v.w3);
    check("frame_ovf", {31'd0, done_ovf}, 0);
    check("frame_csum", {16'd0, done_csum}, {16'd0, exp_sum(v.sum)});
    check("frame_sb_empty", sb_q.size(), 0);
  endtask

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    cyc_n++;
    if (!reset && wr_en && wr_ready) begin
      n_xfer++;
      cap[wr_addr[3:0]] = wr_data;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", {18'd0, wr_addr}, {18'd0, e.addr});
        check("wr_data", wr_data, e.data);
      end
      last_xfer_cyc = cyc_n;
    end
    if (done) begin
      n_done++;
      done_csum = csum;
      done_ovf  = overflow;
      check("done_after_last_write", cyc_n - last_xfer_cyc, 1);
      check("busy_at_done", {31'd0, busy}, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          x0;
    int          d0;
    logic [15:0] held;

    vecs[0] = '{8'h00, 1,  0,  0, 32'h03020100, 32'h0F0E0D0C, 16'd120};
    vecs[1] = '{8'h00, 12, 60, 30, 32'h03020100, 32'h0F0E0D0C, 16'd120};
    vecs[2] = '{8'hF8, 2,  0,  0, 32'hFBFAF9F8, 32'h07060504, 16'h07F8};
    vecs[3] = '{8'h80, 1,  2,  9, 32'h83828180, 32'h8F8E8D8C, 16'h0878};

    reset    = 1'b1;
    start    = 1'b0;
    i_strb   = 1'b0;
    i_data   = 8'h00;
    wr_ready = 1'b1;
    m_reset();
    repeat (3) tick();
    check("rst_wr_en",    {31'd0, wr_en}, 0);
    check("rst_busy",     {31'd0, busy}, 0);
    check("rst_done",     {31'd0, done}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_csum",     {16'd0, csum}, 0);
    check("rst_wr_addr",  {18'd0, wr_addr}, 0);
    check("rst_wr_data",  wr_data, 0);
    reset = 1'b0;
    tick();

    // Table of full frames: pacing, stalls and pixel ranges.
    for (int v = 0; v < 4; v++) run_frame(vecs[v]);

    // Held-off memory: two words buffered, the rest dropped.
    d0 = n_done;
    x0 = n_xfer;
    do_start();
    wr_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      drive_pix(8'(i));
      tick();
      if (i == 7)  check("ovf_before_drop", {31'd0, overflow}, {31'd0, m_ovf});
      if (i == 11) check("ovf_after_drop",  {31'd0, overflow}, {31'd0, m_ovf});
    end
    i_strb = 1'b0;
    tick();
    check("drain_wr_en", {31'd0, wr_en}, 1);
    check("drain_busy",  {31'd0, busy}, 1);
    check("drain_csum",  {16'd0, csum}, {16'd0, exp_sum(m_sum)});
    held = csum;
    for (int i = 0; i < 4; i++) begin
      i_strb = 1'b1;
      i_data = 8'hAA;
      tick();
    end
    i_strb = 1'b0;
    check("drain_strobes_csum", {16'd0, csum}, {16'd0, held});
    check("drain_still_busy", {31'd0, busy}, 1);
    wr_ready = 1'b1;
    wait_done(d0);
    check("ovf_frame_writes", n_xfer - x0, 2);
    check("ovf_word0", cap[0], 32'h03020100);
    check("ovf_word1", cap[1], 32'h07060504);
    check("ovf_sticky_at_done", {31'd0, done_ovf}, 1);

    // Strobes in IDLE: no writes, no state change.
    held = csum;
    x0 = n_xfer;
    for (int i = 0; i < 8; i++) begin
      i_strb = 1'b1;
      i_data = 8'(8'h55 + i);
      tick();
    end
    i_strb = 1'b0;
    tick();
    check("idle_wr_en", {31'd0, wr_en}, 0);
    check("idle_busy",  {31'd0, busy}, 0);
    check("idle_writes", n_xfer - x0, 0);
    check("idle_csum", {16'd0, csum}, {16'd0, held});

    // Restart mid-frame, with a strobe on the start cycle.
    do_start();
    wr_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_pix(8'(8'h40 + i));
      tick();
    end
    i_strb = 1'b0;
    check("restart_ovf_set", {31'd0, overflow}, {31'd0, m_ovf});
    d0 = n_done;
    x0 = n_xfer;
    start  = 1'b1;
    i_strb = 1'b1;
    i_data = 8'hEE;
    tick();
    start  = 1'b0;
    i_strb = 1'b0;
    m_reset();
    check("restart_ovf_clr",  {31'd0, overflow}, 0);
    check("restart_csum_clr", {16'd0, csum}, 0);
    check("restart_wr_en",    {31'd0, wr_en}, 0);
    check("restart_busy",     {31'd0, busy}, 1);
    wr_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      drive_pix(8'(8'h10 + i));
      tick();
    end
    i_strb = 1'b0;
    wait_done(d0);
    check("restart_writes", n_xfer - x0, 4);
    check("restart_word0", cap[0], 32'h13121110);
    check("restart_ovf_done", {31'd0, done_ovf}, 0);
    check("restart_csum_done", {16'd0, done_csum}, {16'd0, exp_sum(16'd376)});

    // Reset while a word waits in DRAIN.
    do_start();
    wr_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      drive_pix(8'(i));
      tick();
    end
    i_strb = 1'b0;
    tick();
    check("pre_reset_wr_en", {31'd0, wr_en}, 1);
    check("pre_reset_busy",  {31'd0, busy}, 1);
    d0 = n_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    check("post_reset_wr_en", {31'd0, wr_en}, 0);
    check("post_reset_busy",  {31'd0, busy}, 0);
    check("post_reset_done",  {31'd0, done}, 0);
    check("post_reset_ovf",   {31'd0, overflow}, 0);
    check("post_reset_addr",  {18'd0, wr_addr}, 0);
    wr_ready = 1'b1;
    x0 = n_xfer;
    repeat (10) tick();
    check("post_reset_writes", n_xfer - x0, 0);
    check("post_reset_no_done", n_done - d0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
